gpioemu_host: RTL

//  Bus initiator for the gpioemu multiply/popcount peripheral. Accepts a 24x24 job on a

---
 rtl/gpioemu_host.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/gpioemu_host.sv
// gpioemu_host: bus initiator that runs one multiply/popcount job on the gpioemu peripheral
// Optional build macro HOST_ONES_CHECK_EN adds a local popcount cross-check driving rsp_mismatch.
module gpioemu_host #(
  parameter int STROBE_CYC = 4,
  parameter int MIN_WAIT   = 8,
  parameter int POLL_MAX   = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [23:0] cmd_a1,
  input  logic [23:0] cmd_a2,
  output logic        rsp_valid,
  output logic [31:0] rsp_result,
  output logic [23:0] rsp_ones,
  output logic        rsp_ovf,
  output logic        rsp_timeout,
  output logic        rsp_mismatch,
  output logic [15:0] op_count,
  output logic [15:0] saddress,
  output logic        srd,
  output logic        swr,
  output logic [31:0] sdata_out,
  input  logic [31:0] sdata_in
);
  typedef enum logic [3:0] {IDLE, WR_A1, WR_A2, WR_CTRL, WAIT, RD_STAT, RD_RES, RD_ONES, RESP} state_t;
  typedef enum logic [1:0] {ADDR, STB, HOLD} ph_t;
  state_t state_q, state_d;
  ph_t ph_q, ph_d;
  logic [15:0] cnt_q, cnt_d, poll_q, poll_d, op_q, op_d, addr;
  logic [23:0] a1_q, a1_d, a2_q, a2_d, rsp_ones_q, rsp_ones_d;
  logic [31:0] res_q, res_d, rsp_res_q, rsp_res_d, wdata;
  logic ovf_q, ovf_d, rsp_ovf_q, rsp_ovf_d, rsp_to_q, rsp_to_d, rsp_mm_q, rsp_mm_d;
  logic acc, wr, done, mm_new;
  // Address and write data belonging to the access the current state performs
  always_comb begin
    addr = state_q == WR_A1 ? 16'h0380 : state_q == WR_A2 ? 16'h0388 :
           state_q == RD_RES ? 16'h0390 : state_q == RD_ONES ? 16'h0398 : 16'h03A0;
    wdata = state_q == WR_A1 ? {8'h0, a1_q} : state_q == WR_A2 ? {8'h0, a2_q} : 32'h1;
  end
  assign wr = state_q inside {WR_A1, WR_A2, WR_CTRL};
  assign acc = wr || state_q inside {RD_STAT, RD_RES, RD_ONES};
  assign done = acc && ph_q == HOLD;
  assign saddress = acc ? addr : '0;
  assign sdata_out = wr ? wdata : '0;
  assign srd = acc && !wr && ph_q == STB;
  assign swr = wr && ph_q == STB;
  assign cmd_ready = state_q == IDLE;
  assign rsp_valid = state_q == RESP;
  assign rsp_result = rsp_res_q;
  assign rsp_ones = rsp_ones_q;
  assign rsp_ovf = rsp_ovf_q;
  assign rsp_timeout = rsp_to_q;
  assign rsp_mismatch = rsp_mm_q;
  assign op_count = op_q;
`ifdef HOST_ONES_CHECK_EN
  logic [23:0] pc;
  // Ones count of the captured product, checked against the value the peripheral reports
  always_comb begin
    pc = '0;
    for (int i = 0; i < 32; i++) pc = pc + 24'(res_q[i]);
  end
  assign mm_new = pc != sdata_in[23:0];
`else
  assign mm_new = 1'b0;
`endif
  // Access phase sequencing, job FSM transitions and response capture
  always_comb begin
    state_d = state_q;
    ph_d = ph_q;
    cnt_d = cnt_q;
    poll_d = poll_q;
    op_d = op_q;
    a1_d = a1_q;
    a2_d = a2_q;
    res_d = res_q;
    ovf_d = ovf_q;
    rsp_res_d = rsp_res_q;
    rsp_ones_d = rsp_ones_q;
    rsp_ovf_d = rsp_ovf_q;
    rsp_to_d = rsp_to_q;
    rsp_mm_d = rsp_mm_q;
    if (acc) begin
      ph_d = ph_q == ADDR ? STB : ph_q == HOLD ? ADDR :
             cnt_q == 16'(STROBE_CYC - 1) ? HOLD : STB;
      cnt_d = ph_q == STB ? cnt_q + 16'd1 : '0;
    end
    case (state_q)
      IDLE: if (cmd_valid) begin
        state_d = WR_A1;
        ph_d = ADDR;
        cnt_d = '0;
        poll_d = '0;
        a1_d = cmd_a1;
        a2_d = cmd_a2;
      end
      WR_A1: if (done) state_d = WR_A2;
      WR_A2: if (done) state_d = WR_CTRL;
      WR_CTRL: if (done) state_d = WAIT;
      WAIT: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == 16'(MIN_WAIT - 1)) begin
          state_d = RD_STAT;
          cnt_d = '0;
        end
      end
      RD_STAT: if (done) begin
        if (sdata_in[1]) begin
          state_d = RD_RES;
          ovf_d = ~sdata_in[0];
        end else if (poll_q + 16'd1 == 16'(POLL_MAX)) begin
          state_d = RESP;
          rsp_res_d = '0;
          rsp_ones_d = '0;
          rsp_ovf_d = 1'b0;
          rsp_to_d = 1'b1;
          rsp_mm_d = 1'b0;
        end else begin
          state_d = WAIT;
          poll_d = poll_q + 16'd1;
        end
      end
      RD_RES: if (done) begin
        state_d = RD_ONES;
        res_d = sdata_in;
      end
      RD_ONES: if (done) begin
        state_d = RESP;
        rsp_res_d = res_q;
        rsp_ones_d = sdata_in[23:0];
        rsp_ovf_d = ovf_q;
        rsp_to_d = 1'b0;
        rsp_mm_d = mm_new;
      end
      RESP: begin
        state_d = IDLE;
        op_d = op_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
  end
  // State and datapath registers; reset discards any job in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ph_q <= ADDR;
      cnt_q <= '0;
      poll_q <= '0;
      op_q <= '0;
      a1_q <= '0;
      a2_q <= '0;
      res_q <= '0;
      ovf_q <= 1'b0;
      rsp_res_q <= '0;
      rsp_ones_q <= '0;
      rsp_ovf_q <= 1'b0;
      rsp_to_q <= 1'b0;
      rsp_mm_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q <= ph_d;
      cnt_q <= cnt_d;
      poll_q <= poll_d;
      op_q <= op_d;
      a1_q <= a1_d;
      a2_q <= a2_d;
      res_q <= res_d;
      ovf_q <= ovf_d;
      rsp_res_q <= rsp_res_d;
      rsp_ones_q <= rsp_ones_d;
      rsp_ovf_q <= rsp_ovf_d;
      rsp_to_q <= rsp_to_d;
      rsp_mm_q <= rsp_mm_d;
    end
  end
endmodule
